// File: rtl/clk_div_manager.sv
// Multi-channel programmable clock divider with per-channel phase/enable and a
// lock sequencer that keeps outputs quiet until every channel is re-aligned.
module clk_div_manager #(
  parameter  int NUM_CH      = 4,
  parameter  int CNT_W       = 16,
  parameter  int LOCK_CYCLES = 256,
  parameter  int DEF_DIV     = 2,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [CNT_W-1:0]  cfg_phase,
  input  logic              cfg_en,
  output logic [NUM_CH-1:0] outclk,
  output logic [NUM_CH-1:0] outclk_stb,
  output logic              locked
);

  localparam int LCW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES + 1) : 1;
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_ALIGN,
    ST_WAIT_LOCK,
    ST_LOCKED
  } state_t;

  state_t             r_state, w_next;
  logic [LCW-1:0]     r_lock_cnt;
  logic               r_armed;
  logic [CNT_W-1:0]   r_div   [NUM_CH];
  logic [CNT_W-1:0]   r_phase [NUM_CH];
  logic [CNT_W-1:0]   r_cnt   [NUM_CH];
  logic [NUM_CH-1:0]  r_en;
  logic [NUM_CH-1:0]  r_outclk, r_stb;

  logic               w_locked;
  logic               w_xfer, w_ch_ok, w_relock, w_run;
  logic [CNT_W-1:0]   w_div_clamp, w_phase_clamp;
  logic [NUM_CH-1:0]  w_hi, w_wrap, w_zero;

  assign w_xfer        = cfg_valid & w_locked;
  assign w_ch_ok       = 32'(cfg_ch) < NUM_CH;
  assign w_relock      = w_xfer & w_ch_ok;
  assign w_run         = w_locked & ~w_relock;
  assign w_div_clamp   = (cfg_div < CNT_W'(2)) ? CNT_W'(2) : cfg_div;
  assign w_phase_clamp = (cfg_phase >= w_div_clamp) ? '0 : cfg_phase;

  always_comb begin
    w_hi   = '0;
    w_wrap = '0;
    w_zero = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_hi[i]   = r_en[i] && ({1'b0, r_cnt[i]} < (({1'b0, r_div[i]} + 1'b1) >> 1));
      w_wrap[i] = (r_cnt[i] == r_div[i] - 1'b1);
      w_zero[i] = r_en[i] && (r_cnt[i] == '0);
    end
  end

  // The first edge after reset stays in ALIGN (r_armed) so lock lands at 2+LOCK_CYCLES.
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_ALIGN;
      r_lock_cnt <= '0;
      r_armed    <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_armed    <= 1'b1;
      r_lock_cnt <= (r_state == ST_WAIT_LOCK) ? r_lock_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_ALIGN:     w_next = r_armed ? ST_WAIT_LOCK : ST_ALIGN;
      ST_WAIT_LOCK: w_next = (r_lock_cnt == LOCK_LAST) ? ST_LOCKED : ST_WAIT_LOCK;
      ST_LOCKED:    w_next = w_relock ? ST_ALIGN : ST_LOCKED;
      default:      w_next = ST_ALIGN;
    endcase
  end

  always_comb begin
    w_locked = (r_state == ST_LOCKED);
  end

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_div[i]   <= CNT_W'(DEF_DIV);
        r_phase[i] <= '0;
        r_cnt[i]   <= '0;
      end
      r_en     <= '1;
      r_outclk <= '0;
      r_stb    <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (r_state == ST_ALIGN)
          r_cnt[i] <= r_en[i] ? r_phase[i] : '0;
        else if (!r_en[i])
          r_cnt[i] <= '0;
        else
          r_cnt[i] <= w_wrap[i] ? '0 : r_cnt[i] + 1'b1;
        if (w_relock && (cfg_ch == CH_W'(i))) begin
          r_div[i]   <= w_div_clamp;
          r_phase[i] <= w_phase_clamp;
          r_en[i]    <= cfg_en;
        end
      end
      r_outclk <= w_run ? w_hi   : '0;
      r_stb    <= w_run ? w_zero : '0;
    end
  end

  assign outclk     = r_outclk;
  assign outclk_stb = r_stb;
  assign locked     = w_locked;
  assign cfg_ready  = w_locked;

endmodule

// File: doc/clk_div_manager.md
Name: clk_div_manager

Overview:
- Parametrised, multi-channel successor to the fixed single-output 50→25 MHz clock block.
- Derives NUM_CH divided clocks and matching one-cycle strobes from refclk.
- Each channel has a runtime-programmable divide ratio, phase offset and enable.
- A lock sequencer holds outputs quiet after reset and after any reconfiguration. It asserts locked once all channels are stable. Sits at the top level feeding the CPU core and peripherals.

Parameters:
- NUM_CH, 4: number of output channels (1..16).
- CNT_W, 16: width of the divide-ratio and phase counters.
- LOCK_CYCLES, 256: refclk cycles spent in WAIT_LOCK before locked asserts (≥1).
- DEF_DIV, 2: divide ratio loaded into every channel at reset (2 gives 25 MHz from 50 MHz).
- CH_W, max(1,$clog2(NUM_CH)): width of cfg_ch (derived, not overridden).

Ports:
- refclk  in  1  reference clock; single clock domain.
- rst  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  high when a request can be accepted.
- cfg_ch  in  CH_W  target channel index.
- cfg_div  in  CNT_W  divide ratio N.
- cfg_phase  in  CNT_W  initial counter offset, in refclk cycles.
- cfg_en  in  1  channel enable.
- outclk  out  NUM_CH  divided clocks, registered.
- outclk_stb  out  NUM_CH  one-refclk pulse per divided period.
- locked  out  1  all channels aligned and running.

Behaviour:
- Reset (rst=0, async), with outputs forced immediately:
  - outclk=0, outclk_stb=0, locked=0, cfg_ready=0.
  - Every channel: div=DEF_DIV, phase=0, en=1, cnt=0.
  - Lock counter=0; FSM=ALIGN.
- FSM states: ALIGN → WAIT_LOCK → LOCKED.
- ALIGN (exactly 1 cycle):
  - Each enabled channel loads cnt=phase.
  - Each disabled channel loads cnt=0.
  - Lock counter cleared. Next state WAIT_LOCK.
- WAIT_LOCK:
  - Enabled counters free-run: cnt = (cnt==N-1) ? 0 : cnt+1.
  - outclk and outclk_stb are gated to 0.
  - Lock counter increments each cycle. After LOCK_CYCLES cycles in WAIT_LOCK, go to LOCKED.
- LOCKED:
  - locked=1, cfg_ready=1, counters keep running.
  - outclk[i] is high in the cycle after cnt[i] < ceil(N/2); the output is registered, so it is glitch-free.
  - outclk_stb[i] is high in the cycle after cnt[i]==0, i.e. coincident with each outclk rising edge.
- Duty cycle:
  - N even: 50%.
  - N odd: high ceil(N/2) cycles, low floor(N/2) cycles.
- Config handshake:
  - A transfer occurs when cfg_valid & cfg_ready (LOCKED only).
  - Channel cfg_ch registers are written on that edge.
  - The FSM goes to ALIGN on the next cycle: locked=0, cfg_ready=0, and all outclk/stb are forced to 0 the cycle after acceptance. A high outclk pulse may therefore be truncated.
  - All channels, including untouched ones, re-align to their stored phases.
- Arithmetic / boundary rules:
  - cfg_div < 2 is stored as 2.
  - cfg_phase ≥ stored N is stored as 0 (no modulo hardware).
  - cfg_ch ≥ NUM_CH: the request is accepted (ready/valid completes) but ignored. No relock; locked stays 1.
  - cfg_valid while not LOCKED: held off (cfg_ready=0); the requester must hold the request until it is accepted.
  - Disabled channel: cnt held at 0, outclk=0, outclk_stb=0 in all states.
- Reset mid-operation (any state, including mid-handshake): immediate return to reset values. Pending configuration is lost and defaults are restored.
- Latency from rst deassertion:
  - First refclk edge: ALIGN.
  - Second edge: WAIT_LOCK.
  - locked rises at edge 2+LOCK_CYCLES.
  - Relock after accepted configuration: locked=1 again 1+LOCK_CYCLES cycles after the cycle in which locked dropped.

Test Plan:
- Reset/lock, with LOCK_CYCLES=16:
  - Stimulus: deassert rst.
  - Required: locked=0 until edge 18, then 1.
  - Required: all outclk low before lock; afterwards period 2, 50% duty, mutually in phase, each stb once per 2 cycles.
- Divide-by-5 reconfiguration:
  - Stimulus: cfg ch1, div=5, phase=0, en=1.
  - Required: locked drops the next cycle, all outclk low, relock after 17 cycles.
  - Required: outclk[1] high 3 / low 2; stb[1] every 5 cycles; other channels unchanged at period 2.
- Phase offset:
  - Stimulus: ch0 div=4 phase=0; ch2 div=4 phase=1.
  - Required: outclk_stb[2] fires exactly 3 cycles after outclk_stb[0], every period.
- Boundary values:
  - div=0 and div=1 → period 2.
  - div=3 with phase=7 → phase 0.
  - cfg_ch=5 with NUM_CH=4 → accepted in one cycle; locked stays 1; outputs undisturbed.
- Disable:
  - Stimulus: ch3 en=0.
  - Required: after relock, outclk[3]=0 and outclk_stb[3]=0 permanently; re-enabling with phase=0 restores period DEF_DIV.
- Asynchronous reset:
  - Stimulus: pull rst low between refclk edges while LOCKED with custom divs.
  - Required: locked, outclk, stb and cfg_ready go 0 without waiting for a refclk edge; after release, all channels run at period 2 again.
